// File: rtl/clkgen_pkg.sv
// Shared constants for the integer clock divider: the divide ratio and the
// width of the counter that walks one output period.
package clkgen_pkg;

    // Returns 0 for a zero output frequency so the caller can reject it cleanly.
    function automatic int div_ratio(input longint in_freq, input longint out_freq);
        if (out_freq == 0) begin
            return 0;
        end
        return int'(in_freq / out_freq);
    endfunction

    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : clkgen_pkg

// File: rtl/clkgen.sv
// Integer clock divider: out is low for floor(N/2) input cycles and then high
// for the remainder of each N-cycle period, always driven from a flop.
module clkgen
    import clkgen_pkg::*;
#(
    parameter int IN_FREQ  = 100000000,
    parameter int OUT_FREQ = 1000000
) (
    input  logic in,
    input  logic reset,
    output logic out
);

    localparam int N = div_ratio(IN_FREQ, OUT_FREQ);
    localparam int W = cnt_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] LOW  = W'(N / 2);

    if (OUT_FREQ == 0 || N < 2) begin : g_bad_ratio
        $error("clkgen: IN_FREQ/OUT_FREQ must give a divide ratio of at least 2");
    end

    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;

    // The output level is decided from the next count so both flops agree on
    // the same edge; the low phase is the shorter one when N is odd.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
        out_d = (cnt_d >= LOW);
    end

    always_ff @(posedge in or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : clkgen

// File: tb/tb_clkgen.sv
// Directed bench for clkgen: four divide ratios run side by side from one
// 100 MHz source, including a reset pulled in the middle of a high phase.
module tb_clkgen;

    logic clk;
    logic rst_n;
    logic out100, out5, out2, out3;

    int vectors;
    int miscompares;
    int k;

    clkgen d100 (.in(clk), .reset(rst_n), .out(out100));
    clkgen #(.IN_FREQ(5), .OUT_FREQ(1)) d5 (.in(clk), .reset(rst_n), .out(out5));
    clkgen #(.IN_FREQ(2), .OUT_FREQ(1)) d2 (.in(clk), .reset(rst_n), .out(out2));
    clkgen #(.IN_FREQ(7), .OUT_FREQ(2)) d3 (.in(clk), .reset(rst_n), .out(out3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Expected levels from the rise-at-k*N+LOW / fall-at-k*N edge schedule.
    function automatic logic exp_out(input int edge_no, input int n, input int low);
        return ((edge_no % n) >= low) ? 1'b1 : 1'b0;
    endfunction

    logic [4:0] tbl5;
    logic [3:0] tbl2;
    logic [5:0] tbl3;

    initial begin
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        rst_n       = 1'b0;

        // Held in reset across several edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out100", 32'(out100), 0);
        check("reset_cnt100", 32'(d100.cnt_q), 0);
        check("reset_out5", 32'(out5), 0);
        check("reset_out2", 32'(out2), 0);
        check("reset_out3", 32'(out3), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Hand tables for edges 1.. after release (bit i = edge i+1).
        tbl5 = 5'b01110;      // N=5: edges 1..5 -> 0,1,1,1,0
        tbl2 = 4'b0101;       // N=2: edges 1..4 -> 1,0,1,0
        tbl3 = 6'b011011;     // N=3: edges 1..6 -> 1,1,0,1,1,0
        for (int i = 0; i < 6; i++) begin
            edge_step();
            if (i < 5) check("n5_table", 32'(out5), 32'(tbl5[i]));
            if (i < 4) check("n2_table", 32'(out2), 32'(tbl2[i]));
            check("n3_table", 32'(out3), 32'(tbl3[i]));
        end

        // Five full periods of the default divider, all ratios checked each edge.
        while (k < 500) begin
            edge_step();
            check("n100_out", 32'(out100), 32'(exp_out(k, 100, 50)));
            check("n5_out", 32'(out5), 32'(exp_out(k, 5, 2)));
            check("n2_out", 32'(out2), 32'(exp_out(k, 2, 1)));
            check("n3_out", 32'(out3), 32'(exp_out(k, 3, 1)));
        end
        check("n100_cnt_wrap", 32'(d100.cnt_q), 0);

        // Advance into the high phase, then pull reset between edges.
        repeat (73) edge_step();
        check("pre_abort_out", 32'(out100), 1);
        check("pre_abort_cnt", 32'(d100.cnt_q), 73);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out", 32'(out100), 0);
        check("abort_cnt", 32'(d100.cnt_q), 0);
        check("abort_out5", 32'(out5), 0);
        edge_step();
        check("abort_hold_out", 32'(out100), 0);

        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (k < 120) begin
            edge_step();
            check("restart_n100", 32'(out100), 32'(exp_out(k, 100, 50)));
            if (k == 49 || k == 50 || k == 100) begin
                check("restart_cnt", 32'(d100.cnt_q), 32'(k % 100));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_clkgen
